// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: two-entry IF/ID pipeline register with skid buffer, flush and drop counter
module if_id_skid_reg #(
    parameter int                INST_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_PCplus4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   PCplus4,
    output logic [1:0]        occupancy,
    output logic [15:0]       flush_drops
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [INST_W-1:0] m_inst_q, m_inst_d, s_inst_q, s_inst_d;
    logic [PC_W-1:0]   m_pc_q, m_pc_d, s_pc_q, s_pc_d;
    logic [15:0]       drops_q, drops_d;
    logic [16:0]       drops_sum;
    logic              accept, drain;

    assign out_valid   = (state_q != EMPTY);
    assign in_ready    = in_ready_q;
    assign inst        = m_inst_q;
    assign PCplus4     = m_pc_q;
    assign occupancy   = (state_q == FULL) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;
    assign flush_drops = drops_q;
    assign accept      = in_valid & in_ready_q;
    assign drain       = out_valid & out_ready;
    assign drops_sum   = {1'b0, drops_q} + {15'd0, occupancy} - {16'd0, drain};

    // Next-state: flush wins; otherwise move entries M/S by accept and drain
    always_comb begin
        state_d  = state_q;
        m_inst_d = m_inst_q;
        m_pc_d   = m_pc_q;
        s_inst_d = s_inst_q;
        s_pc_d   = s_pc_q;
        drops_d  = drops_q;
        if (flush) begin
            state_d  = EMPTY;
            m_inst_d = NOP_INST;
            m_pc_d   = '0;
            s_inst_d = NOP_INST;
            s_pc_d   = '0;
            drops_d  = drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d  = ONE;
                    m_inst_d = in_inst;
                    m_pc_d   = in_PCplus4;
                end
                ONE: if (accept && drain) begin
                    m_inst_d = in_inst;
                    m_pc_d   = in_PCplus4;
                end else if (accept) begin
                    state_d  = FULL;
                    s_inst_d = in_inst;
                    s_pc_d   = in_PCplus4;
                end else if (drain) begin
                    state_d  = EMPTY;
                    m_inst_d = NOP_INST;
                    m_pc_d   = '0;
                end
                FULL: if (drain) begin
                    state_d  = ONE;
                    m_inst_d = s_inst_q;
                    m_pc_d   = s_pc_q;
                    s_inst_d = NOP_INST;
                    s_pc_d   = '0;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    // State registers; in_ready stays low through reset and rises on the first edge after it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            m_inst_q   <= NOP_INST;
            m_pc_q     <= '0;
            s_inst_q   <= NOP_INST;
            s_pc_q     <= '0;
            drops_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_inst_q   <= m_inst_d;
            m_pc_q     <= m_pc_d;
            s_inst_q   <= s_inst_d;
            s_pc_q     <= s_pc_d;
            drops_q    <= drops_d;
        end
    end
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: queue-model check of if_id_skid_reg with directed and random steps
module tb_if_id_skid_reg;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_PCplus4 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] PCplus4;
    logic [1:0]  occupancy;
    logic [15:0] flush_drops;

    if_id_skid_reg dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_PCplus4(in_PCplus4), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .inst(inst),
        .PCplus4(PCplus4), .occupancy(occupancy), .flush_drops(flush_drops)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;

    ent_t        q[$];
    bit          m_rdy = 1'b0;
    int unsigned m_drops = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk({tag, ".inst"}, inst, q.size() > 0 ? q[0].i : 32'h0);
        chk({tag, ".PCplus4"}, PCplus4, q.size() > 0 ? q[0].p : 32'h0);
        chk({tag, ".occupancy"}, {30'd0, occupancy}, q.size());
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, m_rdy});
        chk({tag, ".flush_drops"}, {16'd0, flush_drops}, m_drops);
    endtask

    task automatic step(input string tag, input bit iv, input logic [31:0] ii, input logic [31:0] ip,
                        input bit ordy, input bit fl);
        bit acc, dr;
        in_valid   = iv;
        in_inst    = ii;
        in_PCplus4 = ip;
        out_ready  = ordy;
        flush      = fl;
        acc = iv && m_rdy;
        dr  = ordy && q.size() > 0;
        @(posedge CLK);
        if (fl) begin
            m_drops = m_drops + q.size() - (dr ? 1 : 0);
            if (m_drops > 65535) m_drops = 65535;
            q.delete();
        end else begin
            if (dr) void'(q.pop_front());
            if (acc) q.push_back('{ii, ip});
        end
        m_rdy = q.size() < 2;
        #1;
        chk_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy   = 1'b0;
        m_drops = 0;
    endtask

    initial begin
        int unsigned d0;
        #1 RST = 1'b1;
        model_reset();
        #1 chk_all("reset");
        @(posedge CLK);
        @(posedge CLK);
        #2 RST = 1'b0;
        step("post_rst", 1, 32'h99, 32'h4, 0, 0);
        chk("post_rst_occ", {30'd0, occupancy}, 32'd0);
        chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);

        for (int k = 0; k < 4; k++) begin
            step("stream", 1, 32'h11 * (k + 1), 32'h4 * (k + 1), 1, 0);
            chk("stream_inst", inst, 32'h11 * (k + 1));
            chk("stream_occ", {30'd0, occupancy}, 32'd1);
        end
        step("stream_end", 0, 0, 0, 1, 0);

        step("bp1", 1, 32'hA1, 32'h100, 0, 0);
        step("bp2", 1, 32'hA2, 32'h104, 0, 0);
        chk("bp_full_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        step("bp3_held", 1, 32'hA3, 32'h108, 0, 0);
        chk("bp_stable", inst, 32'hA1);
        step("bp_drain1", 1, 32'hA3, 32'h108, 1, 0);
        chk("bp_order2", inst, 32'hA2);
        step("bp_drain2", 1, 32'hA3, 32'h108, 1, 0);
        chk("bp_order3", inst, 32'hA3);
        step("bp_drain3", 0, 0, 0, 1, 0);

        d0 = m_drops;
        step("fl_b1", 1, 32'hB1, 32'h200, 0, 0);
        step("fl_b2", 1, 32'hB2, 32'h204, 0, 0);
        step("fl_full", 1, 32'hB3, 32'h208, 0, 1);
        chk("fl_full_drops", {16'd0, flush_drops}, d0 + 2);
        chk("fl_full_inst", inst, 32'h0);
        step("fl_after", 0, 0, 0, 1, 0);

        step("fd_c1", 1, 32'hC1, 32'h300, 0, 0);
        d0 = m_drops;
        step("fl_drain", 0, 0, 0, 1, 1);
        chk("fl_drain_drops", {16'd0, flush_drops}, d0);

        for (int k = 0; k < 400; k++)
            step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

        step("ar1", 1, 32'hD1, 32'h400, 0, 0);
        step("ar2", 1, 32'hD2, 32'h404, 0, 0);
        #2 RST = 1'b1;
        model_reset();
        #1 chk_all("async_rst");
        @(posedge CLK);
        #2 RST = 1'b0;
        step("ar_first_edge", 1, 32'hD3, 32'h408, 0, 0);
        chk("ar_rdy", {31'd0, in_ready}, 32'd1);
        step("ar_accept", 1, 32'hD4, 32'h40C, 1, 0);

        while (m_drops < 65535) begin
            step("sat_f1", 1, 32'hE1, 32'h500, 0, 0);
            step("sat_f2", 1, 32'hE2, 32'h504, 0, 0);
            step("sat_fl", 0, 0, 0, 0, 1);
        end
        for (int k = 0; k < 3; k++) begin
            step("sat_f1", 1, 32'hE1, 32'h500, 0, 0);
            step("sat_f2", 1, 32'hE2, 32'h504, 0, 0);
            step("sat_fl", 0, 0, 0, 0, 1);
            chk("sat_hold", {16'd0, flush_drops}, 32'hFFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/if_id_skid_reg.md
IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 Parameter INST_W, default 32, instruction width in bits.
REQ-002 Parameter PC_W, default 32, PC+4 width in bits.
REQ-003 Parameter NOP_INST, default 32'h0000_0000, bubble instruction driven whenever no valid entry is presented.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream (IF) presents an instruction.
REQ-007 in_ready  output  1  stage can accept; driven directly from a state flop, no combinational path from any input.
REQ-008 in_inst  input  INST_W  fetched instruction.
REQ-009 in_PCplus4  input  PC_W  PC+4 of the fetched instruction.
REQ-010 flush  input  1  discard all held entries (branch/jump redirect).
REQ-011 out_valid  output  1  inst/PCplus4 hold a valid entry for ID.
REQ-012 out_ready  input  1  downstream (ID) consumes the presented entry this cycle.
REQ-013 inst  output  INST_W  registered instruction to ID.
REQ-014 PCplus4  output  PC_W  registered PC+4 to ID.
REQ-015 occupancy  output  2  number of valid entries held (0..2).
REQ-016 flush_drops  output  16  count of valid entries discarded by flush.

Function
REQ-017 The block SHALL hold two entries: main register M (drives inst/PCplus4/out_valid) and skid register S.
REQ-018 Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-019 State machine SHALL have states EMPTY (occ 0), ONE (occ 1, M valid), FULL (occ 2, M and S valid); occupancy SHALL equal the state's entry count.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL.
REQ-021 EMPTY: accept -> ONE with M <= input; otherwise stay EMPTY.
REQ-022 ONE: accept & drain -> ONE with M <= input; accept & !drain -> FULL with S <= input, M unchanged; !accept & drain -> EMPTY; neither -> hold.
REQ-023 FULL: drain -> ONE with M <= S, S cleared; no drain -> hold, M and S unchanged.
REQ-024 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or lost except by flush or RST.
REQ-025 Latency: entry accepted at edge N SHALL appear with out_valid=1 after edge N when M was empty or drained at edge N.
REQ-026 While out_valid=1 and out_ready=0, inst and PCplus4 SHALL remain stable.
REQ-027 Whenever M is not valid, inst SHALL be NOP_INST and PCplus4 SHALL be 0.
REQ-028 flush=1 SHALL take precedence over all other events: next state EMPTY, M and S cleared to NOP_INST/0, any simultaneous accept discarded, any simultaneous drain still counts as consumed by ID.
REQ-029 On flush, flush_drops SHALL increase by occupancy minus (1 if drain else 0) that cycle, saturating at 16'hFFFF.
REQ-030 flush_drops SHALL not wrap; it only clears on RST.

Reset
REQ-031 RST=1 SHALL immediately, independent of CLK, force state EMPTY, out_valid=0, in_ready=0, inst=NOP_INST, PCplus4=0, occupancy=0, flush_drops=0, S cleared.
REQ-032 in_ready SHALL rise to 1 on the first rising CLK edge after RST deasserts; no entry SHALL be accepted on that edge.
REQ-033 RST asserted mid-operation (any state, including FULL) SHALL discard all entries without updating flush_drops.

Verification
REQ-034 Streaming: out_ready=1, in_valid=1 for 4 cycles with in_inst 0x11,0x22,0x33,0x44, in_PCplus4 0x4,0x8,0xC,0x10 -> inst 0x11..0x44 on consecutive cycles one cycle after each accept, occupancy stays 1, in_ready stays 1.
REQ-035 Backpressure: out_ready=0, send 0xA1, 0xA2 -> occupancy 2, in_ready=0, inst=0xA1 stable; in_valid with 0xA3 held is not accepted; raise out_ready -> 0xA1, 0xA2, 0xA3 in order, no loss.
REQ-036 Flush in FULL: M=0xB1, S=0xB2, out_ready=0, flush=1 with in_valid=1 (0xB3) -> next cycle EMPTY, out_valid=0, inst=NOP_INST, PCplus4=0, flush_drops=2, 0xB3 never appears.
REQ-037 Flush with drain: state ONE, out_ready=1, flush=1 -> flush_drops unchanged (M consumed), state EMPTY.
REQ-038 Async reset: assert RST between edges while FULL -> outputs reach reset values before next CLK edge; after deassert, in_ready=1 after first edge, flush_drops=0.
REQ-039 Saturation: force 40000 flushes of FULL state -> flush_drops holds 16'hFFFF, no wrap.
